ipe_viol_ctrl: RTL

Consumes the raw IPE and bootcode violation strobes produced by the IP-encapsulation peripheral. Latches them into sticky, software-visible flags and captures the offending address. Drives the NMI request with an `nmi_acc` handshake, and escalates to a PUC request when PUC-on-violation is enabled or the NMI is not accepted in time. Sits between the IPE peripheral and the system/NMI logic, on the 16-bit peripheral bus.

---
 rtl/ipe_viol_ctrl_pkg.sv | 44 ++++
 rtl/viol_addr_sel.sv | 32 +++
 rtl/ipe_viol_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ipe_viol_ctrl_pkg.sv
// Shared definitions for the IPE / bootcode violation controller:
// register offsets, violation bit indices, address classes and FSM states.
package ipe_viol_ctrl_pkg;

    // Register byte offsets from the block base address
    localparam int VIOLFLG_OFF  = 0;
    localparam int VIOLADDR_OFF = 2;
    localparam int VIOLCNT_OFF  = 4;

    // Violation strobe bit positions inside viol_in / VIOLFLG
    localparam int NUM_VIOL   = 8;
    localparam int VB_IPE_FE  = 0;
    localparam int VB_IPE_EU  = 1;
    localparam int VB_IPE_DMA = 2;
    localparam int VB_IPE_DBG = 3;
    localparam int VB_BC_FE   = 4;
    localparam int VB_BC_EU   = 5;
    localparam int VB_BC_DMA  = 6;
    localparam int VB_BC_DBG  = 7;

    // Address-source classes, listed from highest to lowest capture priority
    localparam int NUM_CLASS = 4;
    localparam int CLS_FE    = 0;
    localparam int CLS_EU    = 1;
    localparam int CLS_DMA   = 2;
    localparam int CLS_DBG   = 3;

    // Event counter saturates here
    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_PUC  = 2'd3
    } viol_state_e;

    // IPE and bootcode strobes of the same class share one address source,
    // so fold the two nibbles into a per-class hit vector.
    function automatic logic [NUM_CLASS-1:0] viol_class_hits(input logic [NUM_VIOL-1:0] viol);
        return viol[VB_IPE_DBG:VB_IPE_FE] | viol[VB_BC_DBG:VB_BC_FE];
    endfunction

endpackage

// File: rtl/viol_addr_sel.sv
// Priority selector picking the address to capture for a violation event:
// fetch > execution unit > DMA > debug.
module viol_addr_sel
    import ipe_viol_ctrl_pkg::*;
(
    input  logic [NUM_VIOL-1:0] viol_in,
    input  logic [15:0]         fe_pc_nxt,
    input  logic [15:0]         eu_mab,
    input  logic [15:0]         dma_addr,
    input  logic [15:0]         dbg_mem_addr,
    output logic [15:0]         cap_addr
);

    logic [NUM_CLASS-1:0] class_hit;

    assign class_hit = viol_class_hits(viol_in);

    // Highest-priority active class wins; zero when no strobe is set
    always_comb begin
        cap_addr = 16'h0000;
        if (class_hit[CLS_FE]) begin
            cap_addr = fe_pc_nxt;
        end else if (class_hit[CLS_EU]) begin
            cap_addr = eu_mab;
        end else if (class_hit[CLS_DMA]) begin
            cap_addr = dma_addr;
        end else if (class_hit[CLS_DBG]) begin
            cap_addr = dbg_mem_addr;
        end
    end

endmodule

// File: rtl/ipe_viol_ctrl.sv
// IPE / bootcode violation controller: sticky flags, first-violation address
// capture, saturating event count, and NMI / PUC escalation FSM.
module ipe_viol_ctrl
    import ipe_viol_ctrl_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h05B0,
    parameter int          DEC_WD    = 3,
    parameter int          TIMEOUT   = 16
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    input  logic [7:0]  viol_in,
    input  logic [15:0] fe_pc_nxt,
    input  logic [15:0] eu_mab,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dbg_mem_addr,
    input  logic        puc_on_violation,
    input  logic        nmi_acc,
    output logic [15:0] per_dout,
    output logic        viol_nmi,
    output logic        viol_puc_req,
    output logic        viol_pending
);

    // Register offsets narrowed to the decoder width
    localparam logic [DEC_WD-1:0] OFF_FLG  = DEC_WD'(VIOLFLG_OFF);
    localparam logic [DEC_WD-1:0] OFF_ADDR = DEC_WD'(VIOLADDR_OFF);
    localparam logic [DEC_WD-1:0] OFF_CNT  = DEC_WD'(VIOLCNT_OFF);

    // Timer value in the last REQ cycle before escalating to PUC
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    viol_state_e  state_q, state_d;
    logic [7:0]   timer_q, timer_d;
    logic [7:0]   flg_q,   flg_d;
    logic [15:0]  addr_q,  addr_d;
    logic [7:0]   cnt_q,   cnt_d;

    // ------------------------------------------------------------------
    // Peripheral bus decode (per_addr is a word address, offsets are bytes)
    // ------------------------------------------------------------------
    logic              reg_sel;
    logic [DEC_WD-1:0] reg_off;
    logic              rd_en;
    logic              wr_any;
    logic              flg_wr;
    logic              cnt_wr;

    assign reg_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign reg_off = {per_addr[DEC_WD-2:0], 1'b0};
    assign rd_en   = reg_sel & ~(|per_we);
    assign wr_any  = reg_sel & (|per_we);
    // Flags live in the low byte, so only a low-byte write can clear them
    assign flg_wr  = wr_any & per_we[0] & (reg_off == OFF_FLG);
    assign cnt_wr  = wr_any & (reg_off == OFF_CNT);

    // High byte of the write data has no destination in this block
    logic unused_din_hi;
    assign unused_din_hi = &{1'b0, per_din[15:8]};

    // ------------------------------------------------------------------
    // Violation event and capture address
    // ------------------------------------------------------------------
    logic        viol_evt;
    logic [15:0] cap_addr;

    assign viol_evt = |viol_in;

    viol_addr_sel u_addr_sel (
        .viol_in      (viol_in),
        .fe_pc_nxt    (fe_pc_nxt),
        .eu_mab       (eu_mab),
        .dma_addr     (dma_addr),
        .dbg_mem_addr (dbg_mem_addr),
        .cap_addr     (cap_addr)
    );

    // Next values of the software-visible registers
    always_comb begin
        // New strobes are ORed in after the clear so a same-cycle set survives
        flg_d = (flg_q & ~(flg_wr ? per_din[7:0] : 8'h00)) | viol_in;

        // Only the first violation since the flags were all clear is kept
        addr_d = addr_q;
        if (viol_evt && (flg_q == 8'h00)) begin
            addr_d = cap_addr;
        end

        // A write clears the count, but an event in the same cycle still counts
        cnt_d = cnt_q;
        if (cnt_wr) begin
            cnt_d = viol_evt ? 8'd1 : 8'd0;
        end else if (viol_evt && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Escalation FSM next-state and REQ timer
    always_comb begin
        state_d = state_q;
        timer_d = 8'h00;
        unique case (state_q)
            ST_IDLE: begin
                if (viol_evt) begin
                    state_d = puc_on_violation ? ST_PUC : ST_REQ;
                end
            end
            ST_REQ: begin
                // Acceptance in the final timer cycle still counts as in time
                if (nmi_acc) begin
                    state_d = ST_ACK;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_PUC;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_ACK: begin
                // A fresh violation re-arms the NMI with a fresh timer
                if (viol_evt) begin
                    state_d = ST_REQ;
                end else if (flg_q == 8'h00) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUC: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset so NMI drops immediately
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q <= ST_IDLE;
            timer_q <= 8'h00;
            flg_q   <= 8'h00;
            addr_q  <= 16'h0000;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            flg_q   <= flg_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Combinational register read, zero when not selected
    always_comb begin
        per_dout = 16'h0000;
        if (rd_en) begin
            if (reg_off == OFF_FLG) begin
                per_dout = {8'h00, flg_q};
            end else if (reg_off == OFF_ADDR) begin
                per_dout = addr_q;
            end else if (reg_off == OFF_CNT) begin
                per_dout = {8'h00, cnt_q};
            end
        end
    end

    assign viol_nmi     = (state_q == ST_REQ);
    assign viol_puc_req = (state_q == ST_PUC);
    assign viol_pending = |flg_q;

endmodule
